// File: rtl/id_ex_issue_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, load-use bubble
// insertion, branch flush and a saturating stall-cycle counter.
module id_ex_issue_reg #(
    parameter int unsigned CTRL_W           = 16,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter int unsigned CNT_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1_addr,
    input  logic [4:0]        id_rs2_addr,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        id_rd_addr,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic [31:0]       id_op1,
    input  logic [31:0]       id_op2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd_addr,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_wr_en,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [1:0] BubInit = 2'(LOAD_USE_BUBBLES - 1);

    logic              valid_q;
    logic [31:0]       pc_q, op1_q, op2_q, imm_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic              wr_en_q, is_load_q;
    logic [1:0]        bub_q;
    logic [CNT_W-1:0]  stall_q;

    logic hazard, bub_active, ex_free, accept, stalled;

    // Only a load still in EX with a real destination can create a load-use hazard.
    always_comb begin
        hazard = valid_q && is_load_q && wr_en_q && (rd_q != 5'd0) &&
                 ((id_rs1_used && (id_rs1_addr == rd_q)) ||
                  (id_rs2_used && (id_rs2_addr == rd_q)));
        bub_active = (bub_q != 2'd0);
        ex_free    = !valid_q || ex_ready;
        id_ready   = flush || (ex_free && !hazard && !bub_active);
        accept     = id_valid && id_ready && !flush;
        stalled    = id_valid && !id_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            ctrl_q    <= '0;
            wr_en_q   <= 1'b0;
            is_load_q <= 1'b0;
            bub_q     <= 2'd0;
        end else if (flush) begin
            valid_q <= 1'b0;
            bub_q   <= 2'd0;
        end else if (ex_free) begin
            if (hazard || bub_active) begin
                valid_q <= 1'b0;
                bub_q   <= hazard ? BubInit : bub_q - 2'd1;
            end else if (accept) begin
                valid_q   <= 1'b1;
                pc_q      <= id_pc;
                rs1_q     <= id_rs1_addr;
                rs2_q     <= id_rs2_addr;
                rd_q      <= id_rd_addr;
                op1_q     <= id_op1;
                op2_q     <= id_op2;
                imm_q     <= id_imm;
                ctrl_q    <= id_ctrl;
                wr_en_q   <= id_wr_en;
                is_load_q <= id_is_load;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stalled && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1_addr  = rs1_q;
    assign ex_rs2_addr  = rs2_q;
    assign ex_rd_addr   = rd_q;
    assign ex_op1       = op1_q;
    assign ex_op2       = op2_q;
    assign ex_imm       = imm_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_wr_en     = wr_en_q;
    assign ex_is_load   = is_load_q;
    assign stall_cycles = stall_q;

endmodule
